// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX/MEM status in,
// per-segment enables, flushes and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_ir;
  logic             id_valid;
  logic             ex_take;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ir, id_valid, ex_take, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en,
    input  idex_flush, exmem_en, memwb_en,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ir, id_valid, ex_take, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en,
    output idex_flush, exmem_en, memwb_en,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-segment pipeline: RAW scoreboard,
// branch flush, memory freeze and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic             use_rs;
  logic             use_rt;
  logic [4:0]       dst;
  logic [4:0]       src_a;
  logic [4:0]       src_b;
  logic             hit_a;
  logic             hit_b;
  logic             stall;
  logic             adv;
  logic             stall_ev;
  logic             flush_ev;

  logic [4:0]       sb_ex_q, sb_ex_d;
  logic [4:0]       sb_mem_q, sb_mem_d;
  logic [4:0]       sb_wb_q, sb_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic pc_en, ifid_en, ifid_flush;
  logic idex_en, idex_flush;
  logic exmem_en, memwb_en;

  assign op = bus.id_ir[31:26];
  assign rs = bus.id_ir[25:21];
  assign rt = bus.id_ir[20:16];
  assign rd = bus.id_ir[15:11];

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    dst    = 5'd0;
    unique case (1'b1)
      (op == 6'h00): begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        dst    = rd;
      end
      (op[5:3] == 3'b001),
      (op == 6'h23): begin
        use_rs = 1'b1;
        dst    = rt;
      end
      (op == 6'h2b),
      (op == 6'h04),
      (op == 6'h05): begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      (op == 6'h03): dst = 5'd31;
      default: ;
    endcase
  end

  // A zero source never matches: empty slots and r0 both read as 0.
  assign src_a = use_rs ? rs : 5'd0;
  assign src_b = use_rt ? rt : 5'd0;

  assign hit_a = (src_a != 5'd0) &&
                 ((src_a == sb_ex_q) ||
                  (src_a == sb_mem_q) ||
                  (!WB_BYPASS && (src_a == sb_wb_q)));
  assign hit_b = (src_b != 5'd0) &&
                 ((src_b == sb_ex_q) ||
                  (src_b == sb_mem_q) ||
                  (!WB_BYPASS && (src_b == sb_wb_q)));

  assign stall = bus.id_valid & ~bus.ex_take & (hit_a | hit_b);
  assign adv   = bus.id_valid & ~stall & ~bus.ex_take;

  assign stall_ev = ~rst & ~bus.mem_busy & stall;
  assign flush_ev = ~rst & ~bus.mem_busy & bus.ex_take;

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (bus.mem_busy) begin
      pc_en = 1'b0;
    end else if (bus.ex_take) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (stall) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  always_comb begin
    sb_ex_d  = sb_ex_q;
    sb_mem_d = sb_mem_q;
    sb_wb_d  = sb_wb_q;
    if (!bus.mem_busy) begin
      sb_ex_d  = adv ? dst : 5'd0;
      sb_mem_d = sb_ex_q;
      sb_wb_d  = sb_mem_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_ev && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_ex_q     <= 5'd0;
      sb_mem_q    <= 5'd0;
      sb_wb_q     <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_ex_q     <= sb_ex_d;
      sb_mem_q    <= sb_mem_d;
      sb_wb_q     <= sb_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_en    = idex_en;
  assign bus.idex_flush = idex_flush;
  assign bus.exmem_en   = exmem_en;
  assign bus.memwb_en   = memwb_en;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-segment R/I/J pipeline (IF, ID, EX, MEM, WB).
- Drives per-segment enable and flush strobes, so EXSeg and its neighbours advance, hold or bubble in lockstep.
- Keeps an internal destination-register scoreboard, because there is no forwarding network; stalls ID on RAW hazards.
- Flushes the wrong-path instructions on a taken branch or jump, freezes the whole pipe while memory is busy, and keeps saturating stall and flush counters.

Parameters:
- WB_BYPASS, 1: register file writes before it reads in the same cycle, so the WB slot is excluded from the hazard check.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_ir  in  32  instruction currently in ID.
- id_valid  in  1  ID holds a real instruction; 0 means bubble.
- ex_take  in  1  EX resolved a taken branch or jump this cycle (cond & is-branch/jump).
- mem_busy  in  1  data memory has not completed; freeze the pipe.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID latch enable.
- ifid_flush  out  1  IF/ID latch loads a NOP.
- idex_en  out  1  ID/EX latch enable.
- idex_flush  out  1  ID/EX latch loads a NOP.
- exmem_en  out  1  EX/MEM latch enable.
- memwb_en  out  1  MEM/WB latch enable.
- stall_cnt  out  CNT_W  count of RAW-stall cycles.
- flush_cnt  out  CNT_W  count of taken-branch flush events.

Behaviour:
- Decode of id_ir (op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11]):
  - op 0x00: reads rs, rt; writes rd.
  - op 0x08–0x0F and op 0x23 (lw): read rs; write rt.
  - op 0x2B (sw), 0x04 (beq), 0x05 (bne): read rs, rt; no write.
  - op 0x02 (j): no reads, no write.
  - op 0x03 (jal): writes r31.
  - Any other op: no reads, no write.
  - Destination r0 is encoded as "none" (0).
  - Reads of r0 never hazard.
- Scoreboard:
  - Registers sb_ex, sb_mem, sb_wb, 5 bits each; 0 means empty.
  - They shift sb_ex→sb_mem→sb_wb on every clock edge where mem_busy = 0.
  - sb_ex loads the ID destination if the ID instruction advances (id_valid & ~stall & ~ex_take); otherwise it loads 0.
  - While mem_busy = 1, all scoreboard registers hold.
- stall (comb.) = id_valid & ~ex_take & (some read source ≠ 0 equals sb_ex, sb_mem, or, when WB_BYPASS = 0, sb_wb).
- Output priority, combinational, from current inputs and scoreboard:
  1. rst = 1: all enables 0; ifid_flush = idex_flush = 1.
  2. mem_busy = 1: all enables 0; flushes 0. This holds even if ex_take = 1; the take is honoured once mem_busy drops, since EX holds its cond.
  3. ex_take = 1: all enables 1; ifid_flush = idex_flush = 1.
  4. stall = 1: pc_en = ifid_en = 0; idex_en = 1 with idex_flush = 1 (bubble); exmem_en = memwb_en = 1.
  5. Otherwise: all enables 1; flushes 0.
- Flush has precedence over stall; a stalled instruction on the wrong path is discarded.
- Counters:
  - stall_cnt increments on each edge where case 4 applies.
  - flush_cnt increments on each edge where case 3 applies.
  - Both saturate at all-ones and do not wrap.
- Reset: asynchronous clear of sb_ex, sb_mem, sb_wb, stall_cnt and flush_cnt to 0. Asserting rst mid-stall or mid-freeze discards all pending state immediately.
- Latency: hazard and flush decisions are combinational in the same cycle. Scoreboard state takes effect one edge later.
- Bound on RAW stalls:
  - WB_BYPASS = 1: at most 2 stall cycles for a dependent instruction.
  - WB_BYPASS = 0: at most 3.

Test Plan:
- Reset: rst = 1 for 3 cycles, then released with id_valid = 0 → during reset enables 0 and flushes 1; after release all enables 1, flushes 0, both counters 0.
- RAW on EX: `add r3,r1,r2` (0x00221820) enters ID, then `sub r4,r3,r1` (0x00612022) → 2 stall cycles (pc_en = 0, idex_flush = 1), then it advances; stall_cnt = 2.
- r0 and no-write cases:
  - `addi r0,r0,5` followed by a reader of r0 → no stall.
  - `sw` followed by a reader of its rt → no stall.
- Taken branch during stall: stall active and ex_take = 1 in the same cycle → ifid_flush = idex_flush = 1, pc_en = 1; flush_cnt += 1; stall_cnt unchanged.
- mem_busy freeze: mem_busy held high for 4 cycles while sb_ex = 3 → all enables 0 for 4 cycles and sb_* unchanged; afterwards the shift resumes and the stall resolves on schedule.
- Saturation: CNT_W = 4, 20 consecutive stall cycles → stall_cnt = 15 and holds.
